multicycle_controller: RTL and testbench

Control FSM that sequences the CPU datapath over several clock cycles per instruction instead of one. Instructions and data share one memory port. The controller fetches each instruction into the instruction register and waits on memory with a ready handshake. It drives every datapath enable and mux select per state and updates the PC exactly once per retired instruction. It sits beside the instruction register, register file, ALU, PC muxes and the shared memory port.

---
 rtl/multicycle_controller.sv | 225 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// Multicycle CPU control FSM: fetch/decode/execute/mem/writeback over one shared memory port.
// Latency 2-5 cycles per instruction at zero wait; memory stalls hold FETCH/MEM until memReady.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       aluZero,
  input  logic       memReady,
  output logic       memReq,
  output logic       memInstr,
  output logic       memWrEn,
  output logic       irWrEn,
  output logic       pcWrEn,
  output logic [1:0] pcSrc,
  output logic       regWrEn,
  output logic [1:0] regDst,
  output logic [1:0] writebackSrc,
  output logic       aluSrcB,
  output logic       extSel,
  output logic [2:0] aluCommand,
  output logic       instrDone,
  output logic       halted
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] PC_PLUS4  = 2'd0;
  localparam logic [1:0] PC_RS     = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_BRANCH = 2'd3;

  localparam logic [1:0] DST_RD = 2'd0;
  localparam logic [1:0] DST_RT = 2'd1;
  localparam logic [1:0] DST_RA = 2'd2;

  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_MEM   = 2'd1;
  localparam logic [1:0] WB_PCP4  = 2'd2;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_XOR = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    I_LW, I_SW, I_J, I_JAL, I_BNE, I_ADDI, I_XORI,
    I_JR, I_ADD, I_SUB, I_SLT, I_BAD
  } instr_t;

  state_t state_q, state_d;
  instr_t instr;

  // IR is stable from DECODE onward, so the class is valid in every state that uses it.
  always_comb begin
    instr = I_BAD;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_JR:   instr = I_JR;
          FN_ADD:  instr = I_ADD;
          FN_SUB:  instr = I_SUB;
          FN_SLT:  instr = I_SLT;
          default: instr = I_BAD;
        endcase
      end
      OP_J:    instr = I_J;
      OP_JAL:  instr = I_JAL;
      OP_BNE:  instr = I_BNE;
      OP_ADDI: instr = I_ADDI;
      OP_XORI: instr = I_XORI;
      OP_LW:   instr = I_LW;
      OP_SW:   instr = I_SW;
      default: instr = I_BAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    memReq       = 1'b0;
    memInstr     = 1'b0;
    memWrEn      = 1'b0;
    irWrEn       = 1'b0;
    pcWrEn       = 1'b0;
    pcSrc        = PC_PLUS4;
    regWrEn      = 1'b0;
    regDst       = DST_RD;
    writebackSrc = WB_ALU;
    aluSrcB      = 1'b0;
    extSel       = 1'b0;
    aluCommand   = ALU_ADD;
    instrDone    = 1'b0;
    halted       = 1'b0;

    // ALU controls are held from EXECUTE through MEM/WRITEBACK so aluOut stays valid.
    if (state_q == S_EXECUTE || state_q == S_MEM || state_q == S_WRITEBACK) begin
      aluSrcB = (instr == I_ADDI) || (instr == I_XORI) || (instr == I_LW) || (instr == I_SW);
      extSel  = (instr != I_XORI);
      case (instr)
        I_SUB, I_BNE: aluCommand = ALU_SUB;
        I_XORI:       aluCommand = ALU_XOR;
        I_SLT:        aluCommand = ALU_SLT;
        default:      aluCommand = ALU_ADD;
      endcase
    end

    case (state_q)
      S_FETCH: begin
        memReq   = 1'b1;
        memInstr = 1'b1;
        if (memReady) begin
          irWrEn  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (instr)
          I_J: begin
            pcWrEn  = 1'b1;
            pcSrc   = PC_JUMP;
            state_d = S_FETCH;
          end
          I_JAL: begin
            pcWrEn       = 1'b1;
            pcSrc        = PC_JUMP;
            regWrEn      = 1'b1;
            regDst       = DST_RA;
            writebackSrc = WB_PCP4;
            state_d      = S_FETCH;
          end
          I_JR: begin
            pcWrEn  = 1'b1;
            pcSrc   = PC_RS;
            state_d = S_FETCH;
          end
          I_BAD:   state_d = S_HALT;
          default: state_d = S_EXECUTE;
        endcase
      end
      S_EXECUTE: begin
        case (instr)
          I_BNE: begin
            pcWrEn  = 1'b1;
            pcSrc   = aluZero ? PC_PLUS4 : PC_BRANCH;
            state_d = S_FETCH;
          end
          I_LW, I_SW: state_d = S_MEM;
          default:    state_d = S_WRITEBACK;
        endcase
      end
      S_MEM: begin
        memReq  = 1'b1;
        memWrEn = (instr == I_SW);
        if (memReady) begin
          if (instr == I_SW) begin
            pcWrEn  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: begin
        regWrEn = 1'b1;
        pcWrEn  = 1'b1;
        state_d = S_FETCH;
        case (instr)
          I_LW: begin
            writebackSrc = WB_MEM;
            regDst       = DST_RT;
          end
          I_ADDI, I_XORI: regDst = DST_RT;
          default:        regDst = DST_RD;
        endcase
      end
      S_HALT:  halted = 1'b1;
      default: state_d = S_FETCH;
    endcase

    instrDone = pcWrEn;

    // Outputs are silenced while reset is held so an aborted access never strobes memory.
    if (reset) begin
      memReq       = 1'b0;
      memInstr     = 1'b0;
      memWrEn      = 1'b0;
      irWrEn       = 1'b0;
      pcWrEn       = 1'b0;
      pcSrc        = PC_PLUS4;
      regWrEn      = 1'b0;
      regDst       = DST_RD;
      writebackSrc = WB_ALU;
      aluSrcB      = 1'b0;
      extSel       = 1'b0;
      aluCommand   = ALU_ADD;
      instrDone    = 1'b0;
      halted       = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed per-cycle bench for multicycle_controller; expected output vectors are queued then compared.
module tb_multicycle_controller;

  typedef struct packed {
    logic       memReq;
    logic       memInstr;
    logic       memWrEn;
    logic       irWrEn;
    logic       pcWrEn;
    logic [1:0] pcSrc;
    logic       regWrEn;
    logic [1:0] regDst;
    logic [1:0] writebackSrc;
    logic       aluSrcB;
    logic       extSel;
    logic [2:0] aluCommand;
    logic       instrDone;
    logic       halted;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       aluZero;
  logic       memReady;
  logic       memReq, memInstr, memWrEn, irWrEn, pcWrEn, regWrEn;
  logic       aluSrcB, extSel, instrDone, halted;
  logic [1:0] pcSrc, regDst, writebackSrc;
  logic [2:0] aluCommand;
  exp_t       obs;

  int checks = 0;
  int failures = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct),
    .aluZero(aluZero), .memReady(memReady),
    .memReq(memReq), .memInstr(memInstr), .memWrEn(memWrEn), .irWrEn(irWrEn),
    .pcWrEn(pcWrEn), .pcSrc(pcSrc), .regWrEn(regWrEn), .regDst(regDst),
    .writebackSrc(writebackSrc), .aluSrcB(aluSrcB), .extSel(extSel),
    .aluCommand(aluCommand), .instrDone(instrDone), .halted(halted)
  );

  assign obs = {memReq, memInstr, memWrEn, irWrEn, pcWrEn, pcSrc, regWrEn, regDst,
                writebackSrc, aluSrcB, extSel, aluCommand, instrDone, halted};

  function automatic exp_t mk(input logic mreq, input logic minstr, input logic mwr,
                              input logic irwr, input logic pcwr, input logic [1:0] psrc,
                              input logic rwr, input logic [1:0] rdst, input logic [1:0] wbs,
                              input logic srcb, input logic ext, input logic [2:0] alu,
                              input logic hlt);
    exp_t e;
    e = {mreq, minstr, mwr, irwr, pcwr, psrc, rwr, rdst, wbs, srcb, ext, alu, pcwr, hlt};
    return e;
  endfunction

  function automatic exp_t e_fetch(input logic rdy);
    return mk(1, 1, 0, rdy, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 3'd0, 0);
  endfunction

  function automatic exp_t e_zero();
    return mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 3'd0, 0);
  endfunction

  task automatic check_now();
    exp_t  e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  // Entered and left at posedge+1; outputs are sampled on the falling edge.
  task automatic cyc(input logic rdy, input logic zr, input exp_t e, input string tag);
    memReady = rdy;
    aluZero  = zr;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset    = 1'b1;
    memReady = 1'b1;
    for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, e_zero(), "reset_outputs");
    reset    = 1'b0;
    memReady = 1'b0;
  endtask

  task automatic run_rtype(input logic [5:0] fn, input logic [2:0] alu, input string tag);
    opcode = 6'h00;
    funct  = fn;
    cyc(1, 0, e_fetch(1), {tag, "_fetch"});
    cyc(1, 0, e_zero(), {tag, "_decode"});
    cyc(1, 0, mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 1, alu, 0), {tag, "_exec"});
    cyc(1, 0, mk(0, 0, 0, 0, 1, 2'd0, 1, 2'd0, 2'd0, 0, 1, alu, 0), {tag, "_wb"});
  endtask

  initial begin
    reset    = 1'b1;
    opcode   = 6'h00;
    funct    = 6'h00;
    aluZero  = 1'b0;
    memReady = 1'b0;
    @(posedge clk);
    #1;
    apply_reset();

    // R-type back to back: instrDone once every 4 cycles.
    run_rtype(6'h20, 3'd0, "add0");
    run_rtype(6'h20, 3'd0, "add1");
    run_rtype(6'h22, 3'd1, "sub");
    run_rtype(6'h2A, 3'd3, "slt");

    // LW with three MEM wait cycles: 8 cycles total.
    opcode = 6'h23;
    cyc(1, 0, e_fetch(1), "lw_fetch");
    cyc(1, 0, e_zero(), "lw_decode");
    cyc(1, 0, mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 1, 3'd0, 0), "lw_exec");
    for (int i = 0; i < 3; i++)
      cyc(0, 0, mk(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 1, 3'd0, 0), "lw_mem_wait");
    cyc(1, 0, mk(1, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 1, 3'd0, 0), "lw_mem_ready");
    cyc(1, 0, mk(0, 0, 0, 0, 1, 2'd0, 1, 2'd1, 2'd1, 1, 1, 3'd0, 0), "lw_wb");

    // SW with one fetch wait cycle.
    opcode = 6'h2B;
    cyc(0, 0, e_fetch(0), "sw_fetch_wait");
    cyc(1, 0, e_fetch(1), "sw_fetch");
    cyc(1, 0, e_zero(), "sw_decode");
    cyc(1, 0, mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 1, 3'd0, 0), "sw_exec");
    cyc(1, 0, mk(1, 0, 1, 0, 1, 2'd0, 0, 2'd0, 2'd0, 1, 1, 3'd0, 0), "sw_mem");

    // BNE taken then not taken.
    opcode = 6'h05;
    cyc(1, 0, e_fetch(1), "bne_t_fetch");
    cyc(1, 0, e_zero(), "bne_t_decode");
    cyc(1, 0, mk(0, 0, 0, 0, 1, 2'd3, 0, 2'd0, 2'd0, 0, 1, 3'd1, 0), "bne_taken");
    cyc(1, 1, e_fetch(1), "bne_n_fetch");
    cyc(1, 1, e_zero(), "bne_n_decode");
    cyc(1, 1, mk(0, 0, 0, 0, 1, 2'd0, 0, 2'd0, 2'd0, 0, 1, 3'd1, 0), "bne_not_taken");

    // Jumps complete in DECODE.
    opcode = 6'h03;
    cyc(1, 0, e_fetch(1), "jal_fetch");
    cyc(1, 0, mk(0, 0, 0, 0, 1, 2'd2, 1, 2'd2, 2'd2, 0, 0, 3'd0, 0), "jal_decode");
    opcode = 6'h02;
    cyc(1, 0, e_fetch(1), "j_fetch_after_jal");
    cyc(1, 0, mk(0, 0, 0, 0, 1, 2'd2, 0, 2'd0, 2'd0, 0, 0, 3'd0, 0), "j_decode");
    opcode = 6'h00;
    funct  = 6'h08;
    cyc(1, 0, e_fetch(1), "jr_fetch");
    cyc(1, 0, mk(0, 0, 0, 0, 1, 2'd1, 0, 2'd0, 2'd0, 0, 0, 3'd0, 0), "jr_decode");

    // Immediate ALU ops.
    opcode = 6'h08;
    cyc(1, 0, e_fetch(1), "addi_fetch");
    cyc(1, 0, e_zero(), "addi_decode");
    cyc(1, 0, mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 1, 3'd0, 0), "addi_exec");
    cyc(1, 0, mk(0, 0, 0, 0, 1, 2'd0, 1, 2'd1, 2'd0, 1, 1, 3'd0, 0), "addi_wb");
    opcode = 6'h0E;
    cyc(1, 0, e_fetch(1), "xori_fetch");
    cyc(1, 0, e_zero(), "xori_decode");
    cyc(1, 0, mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 0, 3'd2, 0), "xori_exec");
    cyc(1, 0, mk(0, 0, 0, 0, 1, 2'd0, 1, 2'd1, 2'd0, 1, 0, 3'd2, 0), "xori_wb");

    // Illegal opcode halts; memReady is ignored while halted.
    opcode = 6'h3F;
    cyc(1, 0, e_fetch(1), "ill_fetch");
    cyc(1, 0, e_zero(), "ill_decode");
    for (int i = 0; i < 10; i++)
      cyc(1, 0, mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 3'd0, 1), "halt_hold");
    apply_reset();
    opcode = 6'h00;
    funct  = 6'h3F;
    cyc(0, 0, e_fetch(0), "post_halt_fetch");
    cyc(1, 0, e_fetch(1), "bad_funct_fetch");
    cyc(1, 0, e_zero(), "bad_funct_decode");
    cyc(1, 0, mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 0, 0, 3'd0, 1), "bad_funct_halt");
    apply_reset();

    // Reset during a stalled SW access drops the store strobe asynchronously.
    opcode = 6'h2B;
    cyc(1, 0, e_fetch(1), "swr_fetch");
    cyc(1, 0, e_zero(), "swr_decode");
    cyc(1, 0, mk(0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 1, 3'd0, 0), "swr_exec");
    cyc(0, 0, mk(1, 0, 1, 0, 0, 2'd0, 0, 2'd0, 2'd0, 1, 1, 3'd0, 0), "swr_mem_wait");
    #1;
    reset = 1'b1;
    exp_q.push_back(e_zero());
    tag_q.push_back("swr_async_reset");
    #1;
    check_now();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cyc(0, 0, e_fetch(0), "swr_refetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
